nibble_bus_mem: RTL
===================

# nibble_bus_mem

Memory responder on the downstream side of the 4-bit CPU's nibble bus. Each cycle it decodes the CPU's address and control outputs, then returns the addressed nibble from a program store or a 16-entry data RAM. It also commits CPU store cycles and loads the program store through a valid/ready nibble port while holding the CPU in reset. It sits between the CPU's `uo_out`/`uio_out` pins and its `uio_in[3:0]` input.

## Interface
- PROG_DEPTH, 64, number of 12-bit instruction words in the program store; power of two, at most 256.
- PROG_AW, $clog2(PROG_DEPTH), width of the instruction-index counter.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- bus_addr  in  8  CPU address byte (`uo_out`)
- bus_ctl  in  4  CPU `uio_out[7:4]`
- bus_wdata  in  4  CPU `uio_out[3:0]`; valid on store cycles
- rd_data  out  4  nibble returned to CPU `uio_in[3:0]`
- prog_mode  in  1  high = loader owns the program store
- prog_valid  in  1  nibble offered on prog_data
- prog_data  in  4  program nibble, in instruction order n1, n2, n3
- prog_ready  out  1  loader accepts a nibble this cycle
- prog_full  out  1  program store completely written
- cpu_rst_n  out  1  reset to CPU, active-low
- port_in  in  4  input port (only with NIBBLE_BUS_PORT_EN)
- port_out  out  4  output port register (only with NIBBLE_BUS_PORT_EN)

## Operation
- Cycle decode, using bus_ctl[1:0]:
  - 00, 01 or 10: fetch of nibble n1, n2 or n3.
  - 11: data cycle. bus_ctl[3:2] = 01 is a load; 00 is a store; 10 and 11 are reserved.
- Fetch:
  - Instruction index pc = {bus_addr, bus_ctl[3:2]}.
  - rd_data = nibble (n1 = word[3:0], n2 = word[7:4], n3 = word[11:8]) of word[pc].
  - If pc ≥ PROG_DEPTH, rd_data = 0.
- Load: rd_data = dram[bus_addr[3:0]]. If bus_addr[7:4] ≠ 0, rd_data = 0.
- Store: dram[bus_addr[3:0]] ← bus_wdata at the next posedge, only if bus_addr[7:4] = 0 and cpu_rst_n = 1.
- Reserved cycles: rd_data = 0, no write.
- Loader FSM, states IDLE, LOAD, HOLD:
  - IDLE → LOAD when prog_mode rises. Entry clears the index counter, the phase counter, prog_full and the assembly register.
  - LOAD: prog_ready = !prog_full. On each valid&&ready, the nibble goes into assembly slot phase and phase increments 0→1→2.
  - On phase 2 acceptance, word[index] ← {data, slot1, slot0}, index increments and phase returns to 0.
  - index wrapping from PROG_DEPTH−1 to 0 sets prog_full; prog_ready then stays low.
  - LOAD → HOLD when prog_mode falls. A partially assembled word is discarded.
  - HOLD → IDLE after one cycle.
- cpu_rst_n = 0 in LOAD and HOLD, and 1 in IDLE. The CPU therefore restarts at pc 0 one cycle after prog_mode falls.
- The data RAM is not cleared by the loader; only rst_n clears it.

## Timing
- rd_data is purely combinational from bus inputs and registered storage: zero latency, consumed by the CPU at the same edge.
- A load in the cycle after a store to the same address returns the new value.
- Reset values:
  - rd_data = 0, because storage is cleared.
  - prog_ready = 0, prog_full = 0.
  - cpu_rst_n = 0 during reset, then 1 from the first edge with state IDLE.
  - port_out = 0.
  - All program words and data RAM entries = 0.
- prog_mode asserted during reset takes effect at the first edge after release (IDLE → LOAD).
- rst_n asserted mid-load aborts immediately. All storage is cleared and the FSM returns to IDLE.
- Stores from the bus are ignored while cpu_rst_n = 0.

## Configuration
- NIBBLE_BUS_PORT_EN defined:
  - Data address 0xF is an I/O port.
  - A store to 0xF updates port_out.
  - A load from 0xF returns port_in.
  - dram[15] is not implemented.
- NIBBLE_BUS_PORT_EN undefined: 0xF is ordinary RAM, port_in is unused and port_out is tied to 0.

## Structure
- Shared package nibble_bus_pkg holds:
  - Cycle-type enum (FETCH1, FETCH2, FETCH3, LOAD, STORE, RSVD).
  - The ctl encodings LOAD_CTL = 4'b0111 and STORE_CTL = 4'b0011.
  - Loader state enum.
- One sub-module, nibble_bus_loader: the FSM, counters, assembly register and write strobe for the program store.
- Storage and decode live in the top.

## Test plan
- Load words 0x4A1, 0x830 and 0x000 via prog port, then drop prog_mode:
  - cpu_rst_n stays low one extra cycle.
  - Fetch addr 0x00, ctl 0000/0001/0010 → rd_data 1, A, 4.
  - ctl 0100/0101 → 0, 3.
- Store: addr 0x05, ctl 0011, wdata 0x9; next cycle load addr 0x05, ctl 0111 → rd_data 9. Load addr 0x15 → 0.
- Fill all PROG_DEPTH words → prog_full = 1 and prog_ready = 0. An extra prog_valid changes nothing; word 0 keeps its first value.
- Two nibbles sent, then prog_mode dropped → partial word not written; the fetch still returns the old value.
- With NIBBLE_BUS_PORT_EN:
  - Store 0xC to 0xF → port_out = C.
  - port_in = 6, load 0xF → rd_data 6.
- rst_n pulsed mid-load → FSM in IDLE, prog_ready = 0, all fetches and loads return 0.

Source files
------------

// File: rtl/nibble_bus_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_bus_pkg
// Description : Shared types for the nibble-bus memory responder: cycle-type
//               enum, store/load control encodings, loader state enum and
//               the bus-control decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_bus_pkg;

  // Kind of bus cycle the CPU is running this clock.
  typedef enum logic [2:0] {
    FETCH1 = 3'd0,
    FETCH2 = 3'd1,
    FETCH3 = 3'd2,
    LOAD   = 3'd3,
    STORE  = 3'd4,
    RSVD   = 3'd5
  } cycle_e;

  // Full 4-bit control encodings of the two data cycles.
  localparam logic [3:0] LOAD_CTL  = 4'b0111;
  localparam logic [3:0] STORE_CTL = 4'b0011;

  // Program-loader states.
  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_HOLD = 2'd2
  } loader_state_e;

  // ctl[1:0] selects the fetch nibble; 11 marks a data cycle whose kind is
  // carried in ctl[3:2] (on fetches ctl[3:2] are the low pc bits instead).
  function automatic cycle_e decode_cycle(input logic [3:0] ctl);
    cycle_e cyc;
    case (ctl[1:0])
      2'b00:   cyc = FETCH1;
      2'b01:   cyc = FETCH2;
      2'b10:   cyc = FETCH3;
      default: begin
        if (ctl == LOAD_CTL)       cyc = LOAD;
        else if (ctl == STORE_CTL) cyc = STORE;
        else                       cyc = RSVD;
      end
    endcase
    return cyc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_bus_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_bus_mem_if
// Description : CPU nibble bus between the 4-bit CPU (master) and the memory
//               responder (slave).
//   bus_addr  [7:0] CPU address byte
//   bus_ctl   [3:0] CPU control nibble
//   bus_wdata [3:0] CPU store data
//   rd_data   [3:0] nibble returned to the CPU
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_bus_mem_if;
  logic [7:0] bus_addr;
  logic [3:0] bus_ctl;
  logic [3:0] bus_wdata;
  logic [3:0] rd_data;

  modport master (
    output bus_addr,
    output bus_ctl,
    output bus_wdata,
    input  rd_data
  );

  modport slave (
    input  bus_addr,
    input  bus_ctl,
    input  bus_wdata,
    output rd_data
  );
endinterface
`default_nettype wire

// File: rtl/nibble_bus_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : nibble_bus_loader
// Description : Program-store loader. Holds the CPU in reset while the
//               program port is active, assembles three nibbles per 12-bit
//               instruction word and strobes each finished word into the
//               program store.
//   clk, rst_n          clock, asynchronous active-low reset
//   prog_mode           high = loader owns the program store
//   prog_valid/ready    nibble handshake, prog_data carries n1, n2, n3
//   prog_full           every program word written since LOAD entry
//   cpu_rst_n           active-low reset to the CPU
//   wr_en/addr/data     program-store write strobe (same-cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_bus_loader
  import nibble_bus_pkg::*;
#(
  parameter int PROG_DEPTH = 64,
  parameter int PROG_AW    = $clog2(PROG_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_mode,
  input  logic               prog_valid,
  input  logic [3:0]         prog_data,
  output logic               prog_ready,
  output logic               prog_full,
  output logic               cpu_rst_n,
  output logic               wr_en,
  output logic [PROG_AW-1:0] wr_addr,
  output logic [11:0]        wr_data
);

  loader_state_e      r_state;
  logic               r_mode_q;
  logic [PROG_AW-1:0] r_index;
  logic [1:0]         r_phase;
  logic [3:0]         r_slot0;
  logic [3:0]         r_slot1;
  logic               r_full;
  logic               r_cpu_rst_n;
  logic               w_accept;

  assign prog_ready = (r_state == LD_LOAD) && !r_full;
  assign prog_full  = r_full;
  assign cpu_rst_n  = r_cpu_rst_n;

  // A falling prog_mode wins over a handshake in the same cycle, so the
  // nibble offered then is never taken.
  assign w_accept = prog_valid && prog_ready && prog_mode;

  // Third nibble completes the word: write it in the same cycle it arrives.
  assign wr_en   = w_accept && (r_phase == 2'd2);
  assign wr_addr = r_index;
  assign wr_data = {prog_data, r_slot1, r_slot0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LD_IDLE;
      r_mode_q    <= 1'b0;
      r_index     <= '0;
      r_phase     <= 2'd0;
      r_slot0     <= 4'h0;
      r_slot1     <= 4'h0;
      r_full      <= 1'b0;
      r_cpu_rst_n <= 1'b0;
    end else begin
      // r_mode_q resets low, so prog_mode held through reset is seen as a
      // rising edge at the first clock after release.
      r_mode_q <= prog_mode;
      case (r_state)
        LD_IDLE: begin
          if (prog_mode && !r_mode_q) begin
            r_state     <= LD_LOAD;
            r_index     <= '0;
            r_phase     <= 2'd0;
            r_slot0     <= 4'h0;
            r_slot1     <= 4'h0;
            r_full      <= 1'b0;
            r_cpu_rst_n <= 1'b0;
          end else begin
            r_cpu_rst_n <= 1'b1;
          end
        end
        LD_LOAD: begin
          if (!prog_mode) begin
            // Drop any partially assembled word.
            r_state <= LD_HOLD;
            r_phase <= 2'd0;
          end else if (w_accept) begin
            case (r_phase)
              2'd0: begin
                r_slot0 <= prog_data;
                r_phase <= 2'd1;
              end
              2'd1: begin
                r_slot1 <= prog_data;
                r_phase <= 2'd2;
              end
              default: begin
                r_phase <= 2'd0;
                r_index <= r_index + 1'b1;
                if (r_index == PROG_AW'(PROG_DEPTH - 1)) r_full <= 1'b1;
              end
            endcase
          end
        end
        LD_HOLD: begin
          r_state     <= LD_IDLE;
          r_cpu_rst_n <= 1'b1;
        end
        default: begin
          r_state     <= LD_IDLE;
          r_cpu_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/nibble_bus_mem.sv
`default_nettype none
// ============================================================================
// Module      : nibble_bus_mem
// Description : Memory responder on the CPU nibble bus. Decodes each bus
//               cycle and returns a program nibble or a data-RAM nibble with
//               zero latency, commits CPU stores, and hosts the program
//               loader. Optional I/O port at data address 0xF is enabled by
//               defining NIBBLE_BUS_PORT_EN.
//   clk, rst_n          clock, asynchronous active-low reset
//   bus                 nibble bus (slave modport)
//   prog_*              program loader port
//   cpu_rst_n           active-low reset to the CPU
//   port_in, port_out   I/O port (port_out tied 0 without NIBBLE_BUS_PORT_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_bus_mem
  import nibble_bus_pkg::*;
#(
  parameter int PROG_DEPTH = 64,
  parameter int PROG_AW    = $clog2(PROG_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  nibble_bus_mem_if.slave  bus,
  input  logic             prog_mode,
  input  logic             prog_valid,
  input  logic [3:0]       prog_data,
  output logic             prog_ready,
  output logic             prog_full,
  output logic             cpu_rst_n,
  input  logic [3:0]       port_in,
  output logic [3:0]       port_out
);

`ifdef NIBBLE_BUS_PORT_EN
  localparam logic c_port_en = 1'b1;
`else
  localparam logic c_port_en = 1'b0;
`endif

  logic [11:0]        r_prog [PROG_DEPTH];
  logic [3:0]         r_dram [16];
  logic [3:0]         r_port_out;

  logic               w_prog_we;
  logic [PROG_AW-1:0] w_prog_waddr;
  logic [11:0]        w_prog_wdata;

  cycle_e             w_cycle;
  logic [9:0]         w_pc;
  logic               w_pc_ok;
  logic [11:0]        w_word;
  logic               w_data_ok;
  logic               w_port_hit;
  logic               w_store_ok;
  logic [3:0]         w_rd_data;

  nibble_bus_loader #(
    .PROG_DEPTH (PROG_DEPTH),
    .PROG_AW    (PROG_AW)
  ) u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_mode  (prog_mode),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .prog_full  (prog_full),
    .cpu_rst_n  (cpu_rst_n),
    .wr_en      (w_prog_we),
    .wr_addr    (w_prog_waddr),
    .wr_data    (w_prog_wdata)
  );

  assign w_cycle    = decode_cycle(bus.bus_ctl);
  // On fetch cycles ctl[3:2] extend the address into a 10-bit word index.
  assign w_pc       = {bus.bus_addr, bus.bus_ctl[3:2]};
  assign w_pc_ok    = (w_pc < 10'(PROG_DEPTH));
  assign w_word     = r_prog[w_pc[PROG_AW-1:0]];
  assign w_data_ok  = (bus.bus_addr[7:4] == 4'h0);
  assign w_port_hit = c_port_en && (bus.bus_addr[3:0] == 4'hF);
  assign w_store_ok = (w_cycle == STORE) && w_data_ok && cpu_rst_n;

  always_comb begin
    w_rd_data = 4'h0;
    case (w_cycle)
      FETCH1: if (w_pc_ok) w_rd_data = w_word[3:0];
      FETCH2: if (w_pc_ok) w_rd_data = w_word[7:4];
      FETCH3: if (w_pc_ok) w_rd_data = w_word[11:8];
      LOAD: begin
        if (w_data_ok) w_rd_data = w_port_hit ? port_in : r_dram[bus.bus_addr[3:0]];
      end
      default: w_rd_data = 4'h0;
    endcase
  end

  assign bus.rd_data = w_rd_data;
  assign port_out    = r_port_out;

  // With the port enabled, stores to 0xF go to port_out and dram[15] is
  // never written, so it stays a constant zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PROG_DEPTH; i++) r_prog[i] <= 12'h000;
      for (int i = 0; i < 16; i++) r_dram[i] <= 4'h0;
      r_port_out <= 4'h0;
    end else begin
      if (w_prog_we) r_prog[w_prog_waddr] <= w_prog_wdata;
      if (w_store_ok && !w_port_hit) r_dram[bus.bus_addr[3:0]] <= bus.bus_wdata;
      if (w_store_ok && w_port_hit) r_port_out <= bus.bus_wdata;
    end
  end

endmodule
`default_nettype wire
